data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning word-address bits (depth = 2**ADDR_W words of 32 bits).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait states per access (legal range 0..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_dmtype  input  3  access type (word, half, half-unsigned, byte, byte-unsigned).
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  consumer takes the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data, extended per dmtype; 0 for stores.
REQ-014 SHALL have port rsp_err  output  1  misaligned access flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL capture we/addr/wdata/dmtype when req_valid && req_ready, then go to WAIT, or directly to RESP if WAIT_CYCLES = 0.
REQ-017 SHALL count WAIT_CYCLES cycles in WAIT, then enter RESP; accept-to-rsp_valid latency = WAIT_CYCLES+1 cycles.
REQ-018 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE; no new request is accepted in the same cycle.
REQ-019 SHALL commit a store on the clock edge entering RESP, writing only the addressed byte lanes: word = 4 lanes, half = lanes addr[1]*2+{0,1}, byte = lane addr[1:0].
REQ-020 SHALL produce loads from the word at addr[ADDR_W+1:2]: the byte or half is selected by addr[1:0] and extended (signed for half/byte, zero for the *_unsigned types).
REQ-021 SHALL treat word access with addr[1:0] != 0, or half access with addr[0] = 1, as misaligned: rsp_err = 1, rsp_rdata = 0, no write.
REQ-022 SHALL ignore address bits above ADDR_W+1, so addresses wrap modulo depth.
REQ-023 SHALL treat an undefined dmtype encoding as word.

Reset
REQ-024 SHALL, while rstn = 0, force state IDLE, wait counter 0, req_ready 0, rsp_valid 0, rsp_rdata 0 and rsp_err 0; req_ready rises on the first clock after release.
REQ-025 SHALL, on reset asserted mid-access, abort the access; a store not yet committed SHALL NOT be written.
REQ-026 SHALL NOT reset memory contents.

Configuration
REQ-027 SHALL, with DMEM_MISALIGN_CHECK_EN defined, implement REQ-021; without it, force address bits [1:0] to 0 for word access and bit [0] to 0 for half access, and tie rsp_err to 0.

Structure
REQ-028 SHALL place the dmtype encoding constants and the FSM state type in shared package dmem_pkg.
REQ-029 SHALL instantiate sub-module dmem_array: a 2**ADDR_W x 32 array with synchronous byte-enable write and combinational read.

Verification
REQ-030 SHALL cover: WAIT_CYCLES = 2, store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_valid 3 cycles after accept, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-031 SHALL cover: store byte 0x80 at 0x13, then load byte at 0x13 -> 0xFFFFFF80; load byte-unsigned at 0x13 -> 0x00000080; load word at 0x10 -> 0x80ADBEEF.
REQ-032 SHALL cover: load word at 0x12 with the macro defined -> rsp_err = 1 and rsp_rdata = 0; the word at 0x10 is unchanged. The same load with the macro undefined -> rsp_err = 0 and the word at 0x10 is returned.
REQ-033 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and data stay stable, req_ready stays 0; after the rsp_ready pulse, req_ready = 1 on the next cycle.
REQ-034 SHALL cover: WAIT_CYCLES = 0, ADDR_W = 4, store at 0x40 then load at 0x00 -> the stored value (wrap), with 1-cycle latency.
REQ-035 SHALL cover: rstn pulsed low while in WAIT for a store -> rsp_valid = 0 and the target word keeps its old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-type encodings, controller state type and byte-lane mask helper
package dmem_pkg;
    localparam logic [2:0] DM_WORD  = 3'd0;
    localparam logic [2:0] DM_HALF  = 3'd1;
    localparam logic [2:0] DM_HALFU = 3'd2;
    localparam logic [2:0] DM_BYTE  = 3'd3;
    localparam logic [2:0] DM_BYTEU = 3'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    // Unknown encodings fall through to a full-word mask
    function automatic logic [3:0] lane_mask(input logic [2:0] t, input logic [1:0] a);
        return (t == DM_HALF || t == DM_HALFU) ? (a[1] ? 4'b1100 : 4'b0011) :
               (t == DM_BYTE || t == DM_BYTEU) ? 4'b0001 << a : 4'b1111;
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2**ADDR_W x 32 storage with synchronous byte-enable write and combinational read
module dmem_array #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: wait-stated load/store controller; DMEM_MISALIGN_CHECK_EN enables misalignment errors
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_dmtype,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    state_e            state;
    logic [3:0]        cnt;
    logic              c_we, idle, cur_we, is_half, is_byte, sgn, err, go_resp, mem_we, unused_addr;
    logic [ADDR_W+1:0] c_addr, cur_addr;
    logic [31:0]       c_wdata, cur_wdata, rd, sh, ld;
    logic [2:0]        c_type, cur_type;
    logic [1:0]        a;

    assign unused_addr = ^req_addr[31:ADDR_W+2];
    // In IDLE the live request is used so a zero-wait access can complete on its accept edge
    assign idle      = state == IDLE;
    assign cur_we    = idle ? req_we : c_we;
    assign cur_addr  = idle ? req_addr[ADDR_W+1:0] : c_addr;
    assign cur_wdata = idle ? req_wdata : c_wdata;
    assign cur_type  = idle ? req_dmtype : c_type;
    assign is_half   = cur_type == DM_HALF || cur_type == DM_HALFU;
    assign is_byte   = cur_type == DM_BYTE || cur_type == DM_BYTEU;
    assign sgn       = cur_type == DM_HALF || cur_type == DM_BYTE;
`ifdef DMEM_MISALIGN_CHECK_EN
    assign err = (!is_half && !is_byte && cur_addr[1:0] != 2'b00) || (is_half && cur_addr[0]);
    assign a   = cur_addr[1:0];
`else
    assign err = 1'b0;
    assign a   = is_byte ? cur_addr[1:0] : is_half ? {cur_addr[1], 1'b0} : 2'b00;
`endif
    assign go_resp = idle ? (req_valid && req_ready && WAIT_CYCLES == 0) : (state == WAIT && cnt == LAST);
    assign mem_we  = go_resp && cur_we && !err;
    assign sh      = rd >> {a, 3'b000};
    assign ld      = (err || cur_we) ? 32'h0 :
                     is_byte ? {{24{sgn & sh[7]}}, sh[7:0]} :
                     is_half ? {{16{sgn & sh[15]}}, sh[15:0]} : rd;

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (lane_mask(cur_type, a)),
        .addr  (cur_addr[ADDR_W+1:2]),
        .wdata (is_byte ? {4{cur_wdata[7:0]}} : is_half ? {2{cur_wdata[15:0]}} : cur_wdata),
        .rdata (rd)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            c_we      <= 1'b0;
            c_addr    <= '0;
            c_wdata   <= '0;
            c_type    <= DM_WORD;
        end else if (go_resp) begin
            state     <= RESP;
            req_ready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld;
            rsp_err   <= err;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    state     <= WAIT;
                    cnt       <= '0;
                    req_ready <= 1'b0;
                    c_we      <= req_we;
                    c_addr    <= req_addr[ADDR_W+1:0];
                    c_wdata   <= req_wdata;
                    c_type    <= req_dmtype;
                end else begin
                    req_ready <= 1'b1;
                end
                WAIT: cnt <= cnt + 4'd1;
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of data_mem_ctrl at WAIT_CYCLES=2/ADDR_W=7 and WAIT_CYCLES=0/ADDR_W=4
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, a_valid, b_valid, we, rsp_ready;
    logic [31:0] addr, wdata;
    logic [2:0]  dmtype;
    logic        a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata, exp10;
    int          vecs = 0, errs = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(7), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rstn(rstn), .req_valid(a_valid), .req_ready(a_ready), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_dmtype(dmtype), .rsp_valid(a_rvalid),
        .rsp_ready(rsp_ready), .rsp_rdata(a_rdata), .rsp_err(a_err)
    );

    data_mem_ctrl #(.ADDR_W(4), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rstn(rstn), .req_valid(b_valid), .req_ready(b_ready), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_dmtype(dmtype), .rsp_valid(b_rvalid),
        .rsp_ready(rsp_ready), .rsp_rdata(b_rdata), .rsp_err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One request/response transaction on instance a (b=0) or b (b=1), entered and left at a negedge
    task automatic acc(input bit b, input bit w, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [2:0] t, input logic [31:0] er, input bit ee, input int hold,
                       input string tag);
        int n = 0;
        while (!(b ? b_ready : a_ready) && n < 10) begin @(negedge clk); n++; end
        we = w; addr = ad; wdata = wd; dmtype = t;
        if (b) b_valid = 1'b1; else a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        n = 1;
        while (!(b ? b_rvalid : a_rvalid) && n < 20) begin @(negedge clk); n++; end
        chk({tag, " latency"}, n, b ? 32'd1 : 32'd3);
        chk({tag, " rdata"}, b ? b_rdata : a_rdata, er);
        chk({tag, " err"}, 32'(b ? b_err : a_err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, 32'(b ? b_rvalid : a_rvalid), 32'd1);
            chk({tag, " hold rdata"}, b ? b_rdata : a_rdata, er);
            chk({tag, " hold ready"}, 32'(b ? b_ready : a_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid drop"}, 32'(b ? b_rvalid : a_rvalid), 32'd0);
        chk({tag, " req_ready back"}, 32'(b ? b_ready : a_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; a_valid = 1'b0; b_valid = 1'b0; we = 1'b0; rsp_ready = 1'b0;
        addr = '0; wdata = '0; dmtype = DM_WORD;
        repeat (2) @(negedge clk);
        chk("rst req_ready", 32'(a_ready), 32'd0);
        chk("rst rsp_valid", 32'(a_rvalid), 32'd0);
        chk("rst rsp_rdata", a_rdata, 32'h0);
        chk("rst rsp_err", 32'(a_err), 32'd0);
        rstn = 1'b1;
        #1 chk("ready before first edge", 32'(a_ready), 32'd0);
        @(negedge clk);
        chk("ready after first edge", 32'(a_ready), 32'd1);

        acc(0, 1, 32'h10, 32'hDEADBEEF, DM_WORD,  32'h0,        0, 0, "st_w 0x10");
        acc(0, 0, 32'h10, 32'h0,        DM_WORD,  32'hDEADBEEF, 0, 0, "ld_w 0x10");
        acc(0, 1, 32'h13, 32'h00000080, DM_BYTE,  32'h0,        0, 0, "st_b 0x13");
        acc(0, 0, 32'h13, 32'h0,        DM_BYTE,  32'hFFFFFF80, 0, 0, "ld_b 0x13");
        acc(0, 0, 32'h13, 32'h0,        DM_BYTEU, 32'h00000080, 0, 0, "ld_bu 0x13");
        acc(0, 0, 32'h10, 32'h0,        DM_WORD,  32'h80ADBEEF, 0, 0, "ld_w merged");
        acc(0, 0, 32'h12, 32'h0,        DM_HALF,  32'hFFFF80AD, 0, 0, "ld_h 0x12");
        acc(0, 0, 32'h12, 32'h0,        DM_HALFU, 32'h000080AD, 0, 0, "ld_hu 0x12");
        acc(0, 0, 32'h11, 32'h0,        DM_BYTE,  32'hFFFFFFBE, 0, 0, "ld_b 0x11");
        acc(0, 0, 32'h10, 32'h0,        DM_BYTEU, 32'h000000EF, 0, 0, "ld_bu 0x10");
`ifdef DMEM_MISALIGN_CHECK_EN
        acc(0, 0, 32'h12, 32'h0,        DM_WORD,  32'h0,        1, 0, "ld_w mis 0x12");
        acc(0, 1, 32'h11, 32'h00005555, DM_HALF,  32'h0,        1, 0, "st_h mis 0x11");
        exp10 = 32'h80ADBEEF;
`else
        acc(0, 0, 32'h12, 32'h0,        DM_WORD,  32'h80ADBEEF, 0, 0, "ld_w mis 0x12");
        acc(0, 1, 32'h11, 32'h00005555, DM_HALF,  32'h0,        0, 0, "st_h mis 0x11");
        exp10 = 32'h80AD5555;
`endif
        acc(0, 0, 32'h10, 32'h0,        DM_WORD,  exp10,        0, 0, "ld_w after mis");
        acc(0, 0, 32'h10, 32'h0,        3'd7,     exp10,        0, 0, "ld undef type");
        acc(0, 0, 32'h10, 32'h0,        DM_WORD,  exp10,        0, 5, "backpressure");
        acc(0, 1, 32'h20, 32'hCAFEF00D, DM_WORD,  32'h0,        0, 0, "st_w 0x20");
        acc(0, 0, 32'h220,32'h0,        DM_WORD,  32'hCAFEF00D, 0, 0, "ld_w wrap a");

        we = 1'b1; addr = 32'h20; wdata = 32'h12345678; dmtype = DM_WORD; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        chk("abort in wait ready", 32'(a_ready), 32'd0);
        rstn = 1'b0;
        #1 chk("abort rsp_valid", 32'(a_rvalid), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort held rsp_valid", 32'(a_rvalid), 32'd0);
        chk("abort held ready", 32'(a_ready), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("abort ready back", 32'(a_ready), 32'd1);
        acc(0, 0, 32'h20, 32'h0,        DM_WORD,  32'hCAFEF00D, 0, 0, "ld_w after abort");

        acc(1, 1, 32'h40, 32'h5A5AA5A5, DM_WORD,  32'h0,        0, 0, "b st_w 0x40");
        acc(1, 0, 32'h00, 32'h0,        DM_WORD,  32'h5A5AA5A5, 0, 0, "b ld_w 0x00");
        acc(1, 1, 32'h41, 32'h0000007F, DM_BYTE,  32'h0,        0, 0, "b st_b 0x41");
        acc(1, 0, 32'h00, 32'h0,        DM_HALFU, 32'h00007FA5, 0, 0, "b ld_hu 0x00");
        acc(1, 0, 32'h02, 32'h0,        DM_HALF,  32'h00005A5A, 0, 0, "b ld_h 0x02");
        acc(1, 0, 32'h80, 32'h0,        DM_BYTE,  32'hFFFFFFA5, 0, 0, "b ld_b 0x80");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
